// File: rtl/cache_sim_pkg.sv
// Shared cache-simulator definitions: trace address width and trace feeder state encoding.
package cache_sim_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        ACK   = 3'd4,
        DONE  = 3'd5
    } feeder_state_e;

endpackage

// File: rtl/trace_feeder_if.sv
// Address/lookup handshake between the trace feeder (master) and the cache-simulator top (slave).
interface trace_feeder_if #(
    parameter int AW = cache_sim_pkg::ADDR_W
);
    logic [AW-1:0] mem_addr;
    logic          trace_ready;
    logic          updated;

    modport master (output mem_addr, output trace_ready, input updated);
    modport slave  (input mem_addr, input trace_ready, output updated);
endinterface

// File: rtl/trace_feeder_edge_detect.sv
// Rising-edge detector: pulse is high for the first cycle d is seen high.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);
    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) d_q <= 1'b0;
        else     d_q <= d;
    end

    assign pulse = d & ~d_q;
endmodule

// File: rtl/trace_feeder.sv
// Streams trace BRAM entries to the cache simulator one access at a time, waiting for its ack.
// Optional TRACE_TIMEOUT_EN: give up on an unacknowledged access after TIMEOUT cycles.
module trace_feeder
    import cache_sim_pkg::*;
#(
    parameter int TRACE_DEPTH = 1024,
    parameter int PTR_W       = 10,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PTR_W:0]    trace_len,
    output logic [PTR_W-1:0]  rom_addr,
    input  logic [ADDR_W-1:0] rom_data,
    trace_feeder_if.master    cs,
    output logic [PTR_W:0]    issued_cnt,
    output logic              busy,
    output logic              run_done,
    output logic              timeout_err
);
    localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(TRACE_DEPTH);
    localparam logic [PTR_W:0] ONE   = (PTR_W+1)'(1);

    feeder_state_e  state;
    logic [PTR_W:0] ptr, len_q, len_sat, ptr_nxt;
    logic           ack, tmo, advance;

    edge_detect u_upd_edge (.clk(clk), .rst(rst), .d(cs.updated), .pulse(ack));

    assign len_sat = (trace_len > DEPTH) ? DEPTH : trace_len;
    assign ptr_nxt = ptr + ONE;

`ifdef TRACE_TIMEOUT_EN
    logic [7:0] wait_cnt;
    assign tmo = (state == ACK) && !ack && (wait_cnt == 8'(TIMEOUT));
`else
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif
    assign advance = ack | tmo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rom_addr       <= '0;
            cs.mem_addr    <= '0;
            cs.trace_ready <= 1'b0;
            issued_cnt     <= '0;
            busy           <= 1'b0;
            run_done       <= 1'b0;
            ptr            <= '0;
            len_q          <= '0;
`ifdef TRACE_TIMEOUT_EN
            timeout_err    <= 1'b0;
            wait_cnt       <= '0;
`endif
        end else begin
            cs.trace_ready <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        len_q      <= len_sat;
                        ptr        <= '0;
                        rom_addr   <= '0;
                        issued_cnt <= '0;
`ifdef TRACE_TIMEOUT_EN
                        timeout_err <= 1'b0;
`endif
                        if (len_sat == '0) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            run_done <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            busy     <= 1'b1;
                            run_done <= 1'b0;
                        end
                    end
                end
                FETCH: state <= WAIT;
                // rom_data now reflects the address driven during FETCH
                WAIT: begin
                    state          <= ISSUE;
                    cs.mem_addr    <= rom_data;
                    cs.trace_ready <= 1'b1;
                end
                ISSUE: begin
                    state <= ACK;
`ifdef TRACE_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ACK: begin
                    if (advance) begin
                        if (ack) issued_cnt <= issued_cnt + ONE;
                        ptr      <= ptr_nxt;
                        rom_addr <= ptr_nxt[PTR_W-1:0];
                        if (ptr_nxt == len_q) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            run_done <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
`ifdef TRACE_TIMEOUT_EN
                    if (tmo)       timeout_err <= 1'b1;
                    else if (!ack) wait_cnt    <= wait_cnt + 8'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trace_feeder.sv
// Directed + randomized bench for trace_feeder with a behavioural BRAM and expected-stream model.
module tb_trace_feeder;
    import cache_sim_pkg::*;

    localparam int DEPTH = 1024;
    localparam int PTR_W = 10;

    logic              clk = 1'b0;
    logic              rst, start;
    logic [PTR_W:0]    trace_len;
    logic [PTR_W-1:0]  rom_addr;
    logic [ADDR_W-1:0] rom_data;
    logic [PTR_W:0]    issued_cnt;
    logic              busy, run_done, timeout_err;
    logic [ADDR_W-1:0] rom [DEPTH];
    int                total = 0, bad = 0;

    trace_feeder_if ifc ();

    trace_feeder #(.TRACE_DEPTH(DEPTH), .PTR_W(PTR_W), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .start(start), .trace_len(trace_len),
        .rom_addr(rom_addr), .rom_data(rom_data), .cs(ifc),
        .issued_cnt(issued_cnt), .busy(busy), .run_done(run_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tr(input int lim, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ifc.trace_ready && lat < lim);
    endtask

    task automatic pulse_start(input int len);
        trace_len = (PTR_W+1)'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic ack_pulse();
        ifc.updated = 1'b1;
        tick();
        ifc.updated = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, run_done, 0);
        chk({tag, "_tr"}, ifc.trace_ready, 0);
        chk({tag, "_maddr"}, ifc.mem_addr, 0);
        chk({tag, "_cnt"}, issued_cnt, 0);
        chk({tag, "_raddr"}, rom_addr, 0);
        chk({tag, "_terr"}, timeout_err, 0);
    endtask

    // Expected stream: entries 0..min(len,DEPTH)-1 in order, each 3 cycles after start/ack.
    task automatic run_case(input int len, input int dmin, input int dmax);
        int n, lat;
        n = (len > DEPTH) ? DEPTH : len;
        pulse_start(len);
        for (int i = 0; i < n; i++) begin
            wait_tr(40, lat);
            chk("latency", lat, 3);
            if (!ifc.trace_ready) break;
            chk("addr", ifc.mem_addr, rom[i]);
            tick();
            repeat ($urandom_range(dmax, dmin)) tick();
            chk("addr_hold", ifc.mem_addr, rom[i]);
            ack_pulse();
        end
        @(negedge clk);
        chk("end_done", run_done, 1);
        chk("end_busy", busy, 0);
        chk("end_cnt", issued_cnt, n);
    endtask

    initial begin
        int lat, cnt;
        rst = 1'b1; start = 1'b0; trace_len = '0; ifc.updated = 1'b0;
        for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst");

        // reset in the middle of a wait for ack
        pulse_start(4);
        wait_tr(40, lat);
        chk("pre_rst_tr", ifc.trace_ready, 1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk_reset_vals("midrst");
        tick();
        rst = 1'b0;
        tick();

        // fixed three-entry trace, ack 2 cycles after each lookup
        rom[0] = 32'h1000; rom[1] = 32'h2000; rom[2] = 32'h1010;
        run_case(3, 1, 1);

        // updated held as a level: one count only
        pulse_start(2);
        wait_tr(40, lat);
        chk("lvl_addr0", ifc.mem_addr, rom[0]);
        tick(); tick();
        chk("lvl_hold", ifc.mem_addr, rom[0]);
        ifc.updated = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (ifc.trace_ready) cnt++;
        end
        chk("lvl_pulses", cnt, 1);
        chk("lvl_cnt", issued_cnt, 1);
        chk("lvl_busy", busy, 1);
        chk("lvl_addr1", ifc.mem_addr, rom[1]);
        tick();
        ifc.updated = 1'b0;
        tick();
        ack_pulse();
        @(negedge clk);
        chk("lvl_done", run_done, 1);
        chk("lvl_cnt2", issued_cnt, 2);

        // zero-length run
        pulse_start(0);
        @(negedge clk);
        chk("zero_done", run_done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_cnt", issued_cnt, 0);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifc.trace_ready) cnt++;
        end
        chk("zero_tr", cnt, 0);
        tick();

        // full-depth run, then restart from DONE, then an oversize length
        run_case(DEPTH, 0, 0);
        run_case(3, 0, 3);
        run_case(1500, 0, 0);

        repeat (6) run_case($urandom_range(12, 1), 0, 4);

`ifdef TRACE_TIMEOUT_EN
        pulse_start(2);
        wait_tr(40, lat);
        chk("tmo_addr0", ifc.mem_addr, rom[0]);
        wait_tr(400, lat);
        chk("tmo_lat", lat, 255 + 1 + 3);
        chk("tmo_addr1", ifc.mem_addr, rom[1]);
        chk("tmo_err", timeout_err, 1);
        tick();
        ack_pulse();
        @(negedge clk);
        chk("tmo_done", run_done, 1);
        chk("tmo_cnt", issued_cnt, 1);
        chk("tmo_sticky", timeout_err, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
